// File: rtl/cv32e40x_pkg.sv
// Shared types for the fetch-side helpers that sit between the core and the I-cache.
// Pure type definitions; no logic, no latency.
package cv32e40x_pkg;

  typedef enum logic [2:0] {
    FFR_IDLE,
    FFR_DRAIN,
    FFR_INVAL,
    FFR_ACK,
    FFR_RELEASE
  } fencei_rsp_state_e;

endpackage

// File: rtl/cv32e40x_obi_outstanding_cnt.sv
// Outstanding OBI transaction counter: +1 per grant, -1 per rvalid, sticky error on over/underflow.
// Registered count; cnt_nxt_o is the value the count takes at the next edge.
module cv32e40x_obi_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Over/underflow leaves the count untouched so a drain can still terminate.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_W'(MAX_OUTSTANDING)) err_d = 1'b1;
      else                                   cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign err_o     = err_q;

endmodule

// File: rtl/cv32e40x_fencei_flush_responder.sv
// fence.i responder: block fetches, drain outstanding fetches, invalidate all lines, pulse ack.
// All outputs are Moore decodes of registered state; inv_ready_i low stalls the line walk.
module cv32e40x_fencei_flush_responder
  import cv32e40x_pkg::*;
#(
  parameter int NUM_LINES       = 64,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IDX_W           = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fencei_flush_req_i,
  output logic             fencei_flush_ack_o,
  input  logic             instr_req_i,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  output logic             instr_req_block_o,
  output logic             inv_valid_o,
  output logic [IDX_W-1:0] inv_index_o,
  input  logic             inv_ready_i,
  output logic             busy_o,
  output logic             cnt_err_o
);

  fencei_rsp_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              fetch_inc;

  assign fetch_inc = instr_req_i & ~instr_req_block_o & instr_gnt_i;

  cv32e40x_obi_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_outstanding_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (fetch_inc),
    .dec_i     (instr_rvalid_i),
    .cnt_nxt_o (cnt_nxt),
    .err_o     (cnt_err_o)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      FFR_IDLE: begin
        if (fencei_flush_req_i) state_d = FFR_DRAIN;
      end
      // Leave DRAIN in the same cycle the last rvalid returns.
      FFR_DRAIN: begin
        if (cnt_nxt == '0) begin
          state_d = FFR_INVAL;
          idx_d   = '0;
        end
      end
      FFR_INVAL: begin
        if (inv_ready_i) begin
          if (idx_q == IDX_W'(NUM_LINES - 1)) begin
            state_d = FFR_ACK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FFR_ACK: begin
        state_d = FFR_RELEASE;
      end
      FFR_RELEASE: begin
        if (!fencei_flush_req_i) state_d = FFR_IDLE;
      end
      default: begin
        state_d = FFR_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FFR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign instr_req_block_o  = (state_q != FFR_IDLE);
  assign busy_o             = (state_q != FFR_IDLE);
  assign inv_valid_o        = (state_q == FFR_INVAL);
  assign fencei_flush_ack_o = (state_q == FFR_ACK);
  assign inv_index_o        = idx_q;

endmodule

// File: tb/tb_cv32e40x_fencei_flush_responder.sv
// Bench for the fence.i flush responder: directed scenarios plus randomized flushes,
// every cycle compared against a behavioural model of the flush sequence.
module tb_cv32e40x_fencei_flush_responder;

  localparam int NL = 4;
  localparam int MO = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          ifetch = 1'b0;
  logic          gnt = 1'b0;
  logic          rv = 1'b0;
  logic          rdy = 1'b1;
  logic          fencei_flush_ack_o;
  logic          instr_req_block_o;
  logic          inv_valid_o;
  logic [IW-1:0] inv_index_o;
  logic          busy_o;
  logic          cnt_err_o;

  int n_chk = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 drain, 2 invalidate, 3 ack, 4 release.
  int m_phase = 0;
  int m_idx   = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  cv32e40x_fencei_flush_responder #(
    .NUM_LINES       (NL),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fencei_flush_req_i (req),
    .fencei_flush_ack_o (fencei_flush_ack_o),
    .instr_req_i        (ifetch),
    .instr_gnt_i        (gnt),
    .instr_rvalid_i     (rv),
    .instr_req_block_o  (instr_req_block_o),
    .inv_valid_o        (inv_valid_o),
    .inv_index_o        (inv_index_o),
    .inv_ready_i        (rdy),
    .busy_o             (busy_o),
    .cnt_err_o          (cnt_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int  nc;
    bit  ne;
    bit  inc;
    if (rst) begin
      m_phase <= 0;
      m_idx   <= 0;
      m_cnt   <= 0;
      m_err   <= 1'b0;
    end else begin
      nc  = m_cnt;
      ne  = m_err;
      inc = ifetch && (m_phase == 0) && gnt;
      if (inc && !rv) begin
        if (m_cnt == MO) ne = 1'b1; else nc = m_cnt + 1;
      end else if (rv && !inc) begin
        if (m_cnt == 0) ne = 1'b1; else nc = m_cnt - 1;
      end
      m_cnt <= nc;
      m_err <= ne;
      case (m_phase)
        0: if (req) m_phase <= 1;
        1: if (nc == 0) begin m_phase <= 2; m_idx <= 0; end
        2: if (rdy) begin
             if (m_idx == NL - 1) begin m_phase <= 3; m_idx <= 0; end
             else m_idx <= m_idx + 1;
           end
        3: m_phase <= 4;
        default: if (!req) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy",  busy_o,             m_phase != 0);
    chk("block", instr_req_block_o,  m_phase != 0);
    chk("inv_v", inv_valid_o,        m_phase == 2);
    chk("ack",   fencei_flush_ack_o, m_phase == 3);
    chk("idx",   inv_index_o,        m_idx);
    chk("err",   cnt_err_o,          m_err);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ifetch = 1'b0; gnt = 1'b0; rv = 1'b0; rdy = 1'b1;
  endtask

  // Legal fabric traffic: rvalid only with something outstanding, never overflow.
  task automatic rand_fabric();
    ifetch = 1'($urandom_range(0, 1));
    rv     = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
    gnt    = ifetch && (m_phase == 0) && 1'($urandom_range(0, 1)) && ((m_cnt < MO) || rv);
  endtask

  task automatic flush(input bit rnd, output int lat);
    lat = -1;
    req = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fencei_flush_ack_o) begin lat = k; break; end
      step();
      if (rnd) begin rdy = 1'($urandom_range(0, 1)); rand_fabric(); end
    end
    chk("ack_seen", lat >= 0, 1);
    step();
    if (rnd) repeat ($urandom_range(0, 2)) begin rand_fabric(); step(); end
    req = 1'b0;
  endtask

  initial begin : stim
    int lat;
    int ub;
    int first;
    int held;
    int hold_cycles;
    quiet();
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_ack", fencei_flush_ack_o, 0);
    chk("rst_inv", inv_valid_o, 0);
    step(); step();

    // Idle flush latency and unblock time.
    flush(1'b0, lat);
    chk("idle_ack_lat", lat, NL + 2);
    ub = -1;
    for (int k = lat + 1; k < lat + 20; k++) begin
      @(negedge clk);
      if (!instr_req_block_o) begin ub = k; break; end
      step();
    end
    chk("unblock_lat", ub, NL + 4);
    step(); step();

    // Drain: two fetches outstanding, rvalids in c3 and c5.
    ifetch = 1'b1; gnt = 1'b1; step(); step();
    quiet(); req = 1'b1;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      rv = (k == 3) || (k == 5);
      @(negedge clk);
      if (inv_valid_o && first < 0) first = k;
      if (fencei_flush_ack_o) break;
      step();
    end
    chk("drain_inval_c", first, 6);
    step(); quiet(); req = 1'b0; step(); step();

    // Backpressure on index 1 for 3 cycles.
    req = 1'b1; held = 0; hold_cycles = 0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      rdy = !(inv_valid_o && inv_index_o == 1 && held < 3);
      if (!rdy) held++;
      @(negedge clk);
      if (inv_valid_o && inv_index_o == 1) hold_cycles++;
      if (fencei_flush_ack_o) begin lat = k; break; end
      step();
    end
    chk("bp_hold", hold_cycles, 4);
    chk("bp_ack_lat", lat, NL + 5);
    step(); rdy = 1'b1; req = 1'b0; step(); step();

    // Grant+rvalid together, then a grant in the req cycle.
    ifetch = 1'b1; gnt = 1'b1; step();
    rv = 1'b1; step();
    rv = 1'b0; req = 1'b1;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (inv_valid_o && first < 0) first = k;
      if (fencei_flush_ack_o) break;
      step();
      quiet();
      rv = (k + 1 == 2) || (k + 1 == 4);
    end
    chk("simul_inval_c", first, 5);
    step(); quiet(); req = 1'b0; step(); step();

    // Randomized flushes with background fetch traffic.
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 8)) begin rand_fabric(); step(); end
      rand_fabric();
      flush(1'b1, lat);
      repeat (2) begin rand_fabric(); step(); end
    end
    quiet();
    while (m_cnt > 0) begin rv = 1'b1; step(); end
    quiet(); step(); step();

    // Request dropped before ack: flush still completes.
    req = 1'b1; step(); step(); req = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fencei_flush_ack_o) begin lat = k; break; end
      step();
    end
    chk("drop_ack_seen", lat >= 0, 1);
    step(); step(); step();

    // Reset while invalidating index 2, then restart from index 0.
    req = 1'b1;
    for (int k = 0; k < 20 && !(inv_valid_o && inv_index_o == 2); k++) step();
    chk("reached_idx2", inv_index_o, 2);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_block", instr_req_block_o, 0);
    chk("mid_rst_inv", inv_valid_o, 0);
    chk("mid_rst_idx", inv_index_o, 0);
    chk("mid_rst_ack", fencei_flush_ack_o, 0);
    step(); rst = 1'b0;
    for (int k = 0; k < 20 && !inv_valid_o; k++) step();
    chk("restart_idx", inv_index_o, 0);
    flush(1'b0, lat);
    step(); step();

    // Underflow: rvalid with nothing outstanding.
    rv = 1'b1; step(); rv = 1'b0;
    @(negedge clk);
    chk("err_set", cnt_err_o, 1);
    step();
    flush(1'b0, lat);
    chk("err_flush_lat", lat, NL + 2);
    @(negedge clk);
    chk("err_sticky", cnt_err_o, 1);
    step(); step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
